// File: rtl/point_proc_pkg.sv
// Shared definitions for the point transform block.
// Contents: FSM state encoding, default fixed-point formats, and the
// product/accumulator widths used by the row MAC for rounding and saturation.
package point_proc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW0,
    ST_ROW1,
    ST_ROW2,
    ST_DONE
  } state_t;

  localparam int unsigned FRAC_P_DEF = 16;  // Q15.16 points at W=32
  localparam int unsigned FRAC_R_DEF = 30;  // Q1.30 matrix elements
  localparam int unsigned MAT_W      = 32;  // matrix element width
  localparam int unsigned GUARD_W    = 2;   // headroom for 3 products + translation

  function automatic int unsigned prod_w(input int unsigned w);
    return w + MAT_W;
  endfunction

  function automatic int unsigned acc_w(input int unsigned w);
    return w + MAT_W + GUARD_W;
  endfunction

endpackage

// File: rtl/point_transform_row_mac.sv
// One output row of o = R*p + t, purely combinational.
// Ports:
//   i_m0..i_m2 : matrix row elements, signed Q1.FRAC_R
//   i_p0..i_p2 : point coordinates, signed W bits
//   i_t        : translation for this row, signed W bits
//   o_res      : rounded, saturated coordinate, signed W bits
//   o_sat      : o_res was clipped to the W-bit range
module point_transform_row_mac
  import point_proc_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned FRAC_R = FRAC_R_DEF
) (
  input  logic signed [MAT_W-1:0] i_m0,
  input  logic signed [MAT_W-1:0] i_m1,
  input  logic signed [MAT_W-1:0] i_m2,
  input  logic signed [W-1:0]     i_p0,
  input  logic signed [W-1:0]     i_p1,
  input  logic signed [W-1:0]     i_p2,
  input  logic signed [W-1:0]     i_t,
  output logic signed [W-1:0]     o_res,
  output logic                    o_sat
);

  localparam int unsigned PW    = prod_w(W);
  localparam int unsigned ACC_W = acc_w(W);

  // Half an LSB of the result: rounds half toward +inf after the shift.
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1) << (FRAC_R - 1);
  localparam logic signed [ACC_W-1:0] O_MAX = (ACC_W'(1) << (W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] O_MIN = ~O_MAX;

  logic signed [PW-1:0]    w_prod0, w_prod1, w_prod2;
  logic signed [ACC_W-1:0] w_t_ext, w_sum, w_rnd;

  always_comb begin
    w_prod0 = PW'(i_m0) * PW'(i_p0);
    w_prod1 = PW'(i_m1) * PW'(i_p1);
    w_prod2 = PW'(i_m2) * PW'(i_p2);
    w_t_ext = ACC_W'(i_t);
    // Translation is aligned to the product scale before summing so nothing
    // is truncated until the single final shift.
    w_sum   = ACC_W'(w_prod0) + ACC_W'(w_prod1) + ACC_W'(w_prod2)
            + (w_t_ext <<< FRAC_R) + RND;
    w_rnd   = w_sum >>> FRAC_R;

    o_sat = 1'b0;
    o_res = w_rnd[W-1:0];
    if (w_rnd > O_MAX) begin
      o_sat = 1'b1;
      o_res = O_MAX[W-1:0];
    end else if (w_rnd < O_MIN) begin
      o_sat = 1'b1;
      o_res = O_MIN[W-1:0];
    end
  end

endmodule

// File: rtl/point_transform.sv
// Rigid point transform o = R*p + t, one matrix row per cycle on a shared
// three-multiplier MAC.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   mat_valid           : load strobe for r00..r22 / tx,ty,tz into the shadow set
//   r00..r22            : rotation matrix, signed Q1.FRAC_R
//   tx,ty,tz            : translation, signed W bits
//   in_valid / in_ready : point input handshake (px,py,pz)
//   out_valid/out_ready : result handshake (ox,oy,oz,out_sat)
//   out_sat             : at least one output coordinate was saturated
module point_transform
  import point_proc_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned FRAC_P = FRAC_P_DEF,
  parameter int unsigned FRAC_R = FRAC_R_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mat_valid,
  input  logic signed [MAT_W-1:0] r00, r01, r02,
  input  logic signed [MAT_W-1:0] r10, r11, r12,
  input  logic signed [MAT_W-1:0] r20, r21, r22,
  input  logic signed [W-1:0]     tx, ty, tz,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W-1:0]     px, py, pz,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W-1:0]     ox, oy, oz,
  output logic                    out_sat
);

  if (FRAC_P >= W || FRAC_R >= MAT_W || FRAC_R == 0) begin : g_bad_cfg
    $error("point_transform: unsupported fixed-point configuration");
  end

  state_t r_state, w_next;
  logic   r_loaded;
  logic   w_accept;

  logic signed [MAT_W-1:0] w_mat_in [9];
  logic signed [MAT_W-1:0] r_sh_m [9];
  logic signed [MAT_W-1:0] r_ac_m [9];
  logic signed [W-1:0]     r_sh_t [3];
  logic signed [W-1:0]     r_ac_t [3];
  logic signed [W-1:0]     r_p    [3];
  logic signed [W-1:0]     r_ox, r_oy, r_oz;
  logic                    r_sat;

  logic signed [MAT_W-1:0] w_m0, w_m1, w_m2;
  logic signed [W-1:0]     w_t, w_res;
  logic                    w_sat;

  assign w_mat_in = '{r00, r01, r02, r10, r11, r12, r20, r21, r22};
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = r_loaded;
        if (in_valid && r_loaded) w_next = ST_ROW0;
      end
      ST_ROW0: w_next = ST_ROW1;
      ST_ROW1: w_next = ST_ROW2;
      ST_ROW2: w_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Shadow set: written on every strobe regardless of FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_loaded <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) r_sh_m[i] <= '0;
      for (int unsigned i = 0; i < 3; i++) r_sh_t[i] <= '0;
    end else if (mat_valid) begin
      r_loaded <= 1'b1;
      for (int unsigned i = 0; i < 9; i++) r_sh_m[i] <= w_mat_in[i];
      r_sh_t[0] <= tx;
      r_sh_t[1] <= ty;
      r_sh_t[2] <= tz;
    end
  end

  // Active set and point snapshot; copying the pre-edge shadow means a
  // strobe on the acceptance cycle only affects later points.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 9; i++) r_ac_m[i] <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        r_ac_t[i] <= '0;
        r_p[i]    <= '0;
      end
    end else if (w_accept) begin
      for (int unsigned i = 0; i < 9; i++) r_ac_m[i] <= r_sh_m[i];
      for (int unsigned i = 0; i < 3; i++) r_ac_t[i] <= r_sh_t[i];
      r_p[0] <= px;
      r_p[1] <= py;
      r_p[2] <= pz;
    end
  end

  always_comb begin
    w_m0 = r_ac_m[0];
    w_m1 = r_ac_m[1];
    w_m2 = r_ac_m[2];
    w_t  = r_ac_t[0];
    if (r_state == ST_ROW1) begin
      w_m0 = r_ac_m[3];
      w_m1 = r_ac_m[4];
      w_m2 = r_ac_m[5];
      w_t  = r_ac_t[1];
    end else if (r_state == ST_ROW2) begin
      w_m0 = r_ac_m[6];
      w_m1 = r_ac_m[7];
      w_m2 = r_ac_m[8];
      w_t  = r_ac_t[2];
    end
  end

  point_transform_row_mac #(
    .W      (W),
    .FRAC_R (FRAC_R)
  ) u_row_mac (
    .i_m0  (w_m0),
    .i_m1  (w_m1),
    .i_m2  (w_m2),
    .i_p0  (r_p[0]),
    .i_p1  (r_p[1]),
    .i_p2  (r_p[2]),
    .i_t   (w_t),
    .o_res (w_res),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ox  <= '0;
      r_oy  <= '0;
      r_oz  <= '0;
      r_sat <= 1'b0;
    end else begin
      case (r_state)
        ST_ROW0: begin
          r_ox  <= w_res;
          r_sat <= w_sat;
        end
        ST_ROW1: begin
          r_oy  <= w_res;
          r_sat <= r_sat | w_sat;
        end
        ST_ROW2: begin
          r_oz  <= w_res;
          r_sat <= r_sat | w_sat;
        end
        default: ;
      endcase
    end
  end

  assign ox      = r_ox;
  assign oy      = r_oy;
  assign oz      = r_oz;
  assign out_sat = r_sat;

endmodule

// File: tb/tb_point_transform.sv
// Self-checking bench for point_transform (default W=32, FRAC_R=30).
module tb_point_transform;

  typedef logic [8:0][31:0] mat_t;
  typedef logic [2:0][31:0] vec_t;

  typedef struct {
    string       name;
    mat_t        m;
    vec_t        t;
    vec_t        p;
    logic [96:0] exp;
  } vec_rec_t;

  logic        clk, rst, mat_valid, in_valid, in_ready, out_valid, out_ready, out_sat;
  mat_t        mat_in;
  vec_t        t_in, p_in;
  logic [31:0] ox, oy, oz;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the shadow/active sets should hold.
  mat_t sh_m, ac_m;
  vec_t sh_t, ac_t, ac_p;
  bit   m_loaded;

  point_transform #(.W(32), .FRAC_P(16), .FRAC_R(30)) dut (
    .clk(clk), .rst(rst), .mat_valid(mat_valid),
    .r00(mat_in[0]), .r01(mat_in[1]), .r02(mat_in[2]),
    .r10(mat_in[3]), .r11(mat_in[4]), .r12(mat_in[5]),
    .r20(mat_in[6]), .r21(mat_in[7]), .r22(mat_in[8]),
    .tx(t_in[0]), .ty(t_in[1]), .tz(t_in[2]),
    .in_valid(in_valid), .in_ready(in_ready),
    .px(p_in[0]), .py(p_in[1]), .pz(p_in[2]),
    .out_valid(out_valid), .out_ready(out_ready),
    .ox(ox), .oy(oy), .oz(oz), .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic mat_t mk_mat(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    mat_t m;
    m[0] = a0; m[1] = a1; m[2] = a2;
    m[3] = a3; m[4] = a4; m[5] = a5;
    m[6] = a6; m[7] = a7; m[8] = a8;
    return m;
  endfunction

  function automatic vec_t mk_vec(input logic [31:0] a, b, c);
    vec_t v;
    v[0] = a; v[1] = b; v[2] = c;
    return v;
  endfunction

  // One coordinate from the arithmetic definition: exact value of
  // (sum r*p + t*2^30) / 2^30, rounded half up, clipped to 32-bit signed.
  function automatic logic [32:0] ref_row(input mat_t m, input vec_t p, input vec_t t, input int r);
    logic signed [127:0] acc, a, b, q;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      a   = $signed(m[3*r+k]);
      b   = $signed(p[k]);
      acc = acc + a * b;
    end
    a   = $signed(t[r]);
    acc = acc + a * 128'sd1073741824;
    q   = (acc + 128'sd536870912) >>> 30;
    if (q > 128'sd2147483647)  return {1'b1, 32'h7FFFFFFF};
    if (q < -128'sd2147483648) return {1'b1, 32'h80000000};
    return {1'b0, q[31:0]};
  endfunction

  function automatic logic [96:0] ref_point(input mat_t m, input vec_t p, input vec_t t);
    logic [32:0] r0, r1, r2;
    r0 = ref_row(m, p, t, 0);
    r1 = ref_row(m, p, t, 1);
    r2 = ref_row(m, p, t, 2);
    return {r0[31:0], r1[31:0], r2[31:0], r0[32] | r1[32] | r2[32]};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 32'h000FFFFF)) - 32'h00080000;
      2:       return ($urandom_range(0, 1) != 0) ? 32'h40000000 : 32'hC0000000;
      default: return 32'($urandom_range(0, 32'h3FFFFFFF)) - 32'h20000000;
    endcase
  endfunction

  function automatic mat_t rnd_mat();
    mat_t m;
    for (int i = 0; i < 9; i++) m[i] = rnd32();
    return m;
  endfunction

  function automatic vec_t rnd_vec();
    return mk_vec(rnd32(), rnd32(), rnd32());
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (mat_valid) begin
      sh_m     = mat_in;
      sh_t     = t_in;
      m_loaded = 1'b1;
    end
    #1;
  endtask

  task automatic load_mat(input mat_t m, input vec_t t);
    mat_in    = m;
    t_in      = t;
    mat_valid = 1'b1;
    cyc();
    mat_valid = 1'b0;
    mat_in    = rnd_mat();
    t_in      = rnd_vec();
  endtask

  task automatic send_point(input vec_t p, input bit mv, input mat_t nm, input vec_t nt);
    int w = 0;
    while (!in_ready && w < 50) begin
      cyc();
      w++;
    end
    check("in_ready_before_accept", in_ready, m_loaded);
    p_in     = p;
    in_valid = 1'b1;
    if (mv) begin
      mat_valid = 1'b1;
      mat_in    = nm;
      t_in      = nt;
    end
    ac_m = sh_m;
    ac_t = sh_t;
    ac_p = p;
    cyc();
    in_valid  = 1'b0;
    mat_valid = 1'b0;
    p_in      = rnd_vec();
    mat_in    = rnd_mat();
    t_in      = rnd_vec();
  endtask

  // Counts edges after the acceptance edge until out_valid is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
  endtask

  mat_t IDENT, RZ90, ZM;
  vec_t ZV;
  vec_rec_t tbl[$];

  function automatic vec_rec_t mk_rec(input string nm, input mat_t m, input vec_t t,
                                      input vec_t p, input logic [96:0] e);
    vec_rec_t r;
    r.name = nm; r.m = m; r.t = t; r.p = p; r.exp = e;
    return r;
  endfunction

  initial begin
    int n;
    logic [96:0] e;

    IDENT = mk_mat(32'h40000000, 0, 0, 0, 32'h40000000, 0, 0, 0, 32'h40000000);
    RZ90  = mk_mat(0, 32'hC0000000, 0, 32'h40000000, 0, 0, 0, 0, 32'h40000000);
    ZM    = '0;
    ZV    = '0;
    sh_m = '0; sh_t = '0; ac_m = '0; ac_t = '0; ac_p = '0; m_loaded = 1'b0;

    tbl.push_back(mk_rec("identity", IDENT, ZV, mk_vec(32'h00010000, 32'h00020000, 32'h00030000),
                         {32'h00010000, 32'h00020000, 32'h00030000, 1'b0}));
    tbl.push_back(mk_rec("rz90", RZ90, ZV, mk_vec(32'h00010000, 32'h00020000, 32'h00030000),
                         {32'hFFFE0000, 32'h00010000, 32'h00030000, 1'b0}));
    tbl.push_back(mk_rec("sat_pos", IDENT, mk_vec(32'h00020000, 0, 0), mk_vec(32'h7FFF0000, 0, 0),
                         {32'h7FFFFFFF, 32'h0, 32'h0, 1'b1}));
    tbl.push_back(mk_rec("round_half_pos", mk_mat(32'h20000000, 0, 0, 0, 0, 0, 0, 0, 0), ZV,
                         mk_vec(32'h1, 0, 0), {32'h1, 32'h0, 32'h0, 1'b0}));
    tbl.push_back(mk_rec("round_half_neg", mk_mat(32'h20000000, 0, 0, 0, 0, 0, 0, 0, 0), ZV,
                         mk_vec(32'hFFFFFFFF, 0, 0), {32'h0, 32'h0, 32'h0, 1'b0}));
    tbl.push_back(mk_rec("sat_neg", IDENT, mk_vec(32'hFFFFFFFF, 0, 0), mk_vec(32'h80000000, 0, 0),
                         {32'h80000000, 32'h0, 32'h0, 1'b1}));
    tbl.push_back(mk_rec("rz90_sat", RZ90, ZV, mk_vec(0, 32'h80000000, 0),
                         {32'h7FFFFFFF, 32'h0, 32'h0, 1'b1}));

    // Reset state, and no readiness before the first matrix load.
    rst = 1'b1; mat_valid = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    mat_in = '0; t_in = '0; p_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {in_ready, out_valid, ox, oy, oz, out_sat}, '0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("no_ready_before_load", {in_ready, out_valid}, 2'b00);
    end
    in_valid = 1'b0;

    // Directed table; latency from acceptance (cycle T) to out_valid (T+4).
    foreach (tbl[i]) begin
      load_mat(tbl[i].m, tbl[i].t);
      send_point(tbl[i].p, 1'b0, ZM, ZV);
      wait_done(n);
      check({tbl[i].name, "_latency"}, n, 3);
      check(tbl[i].name, {out_valid, ox, oy, oz, out_sat}, {1'b1, tbl[i].exp});
      cyc();
    end

    // Back-pressure: result and handshake outputs hold while out_ready is low.
    load_mat(IDENT, mk_vec(0, 0, 32'h00010000));
    out_ready = 1'b0;
    send_point(mk_vec(32'h00050000, 32'hFFFB0000, 32'h7FFFFFFF), 1'b0, ZM, ZV);
    e = ref_point(ac_m, ac_p, ac_t);
    wait_done(n);
    for (int i = 0; i < 10; i++) begin
      check("hold_stable", {out_valid, in_ready, ox, oy, oz, out_sat}, {2'b10, e});
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    check("release_to_idle", {out_valid, in_ready}, 2'b01);

    // Strobes on the acceptance cycle and during ROW1 go to the shadow only.
    load_mat(IDENT, ZV);
    send_point(mk_vec(32'h00010000, 32'h00020000, 32'h00030000), 1'b1, RZ90, ZV);
    cyc();
    mat_valid = 1'b1; mat_in = RZ90; t_in = ZV;
    cyc();
    mat_valid = 1'b0;
    wait_done(n);
    check("inflight_keeps_identity", {out_valid, ox, oy, oz, out_sat},
          {1'b1, 32'h00010000, 32'h00020000, 32'h00030000, 1'b0});
    cyc();
    send_point(mk_vec(32'h00010000, 32'h00020000, 32'h00030000), 1'b0, ZM, ZV);
    wait_done(n);
    check("next_uses_rz90", {out_valid, ox, oy, oz, out_sat},
          {1'b1, 32'hFFFE0000, 32'h00010000, 32'h00030000, 1'b0});
    cyc();

    // Reset during ROW1 drops the point and the loaded matrix.
    load_mat(IDENT, ZV);
    send_point(mk_vec(32'h00070000, 32'h00080000, 32'h00090000), 1'b0, ZM, ZV);
    cyc();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    sh_m = '0; sh_t = '0; m_loaded = 1'b0;
    check("reset_midflight", {in_ready, out_valid, ox, oy, oz, out_sat}, '0);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("no_stale_after_reset", {in_ready, out_valid}, 2'b00);
    end
    in_valid = 1'b0;
    load_mat(RZ90, ZV);
    check("ready_after_reload", in_ready, 1'b1);
    send_point(mk_vec(32'h00010000, 32'h00020000, 32'h00030000), 1'b0, ZM, ZV);
    wait_done(n);
    check("after_reset_result", {out_valid, ox, oy, oz, out_sat},
          {1'b1, 32'hFFFE0000, 32'h00010000, 32'h00030000, 1'b0});
    cyc();

    // Randomized traffic against the reference model.
    for (int it = 0; it < 60; it++) begin
      int k, d;
      if (it == 0 || $urandom_range(0, 1) != 0) load_mat(rnd_mat(), rnd_vec());
      send_point(rnd_vec(), ($urandom_range(0, 3) == 0), rnd_mat(), rnd_vec());
      e = ref_point(ac_m, ac_p, ac_t);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        repeat (k) cyc();
        mat_valid = 1'b1; mat_in = rnd_mat(); t_in = rnd_vec();
        cyc();
        mat_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 1) != 0);
      wait_done(n);
      if (!out_ready) begin
        d = $urandom_range(0, 3);
        repeat (d) cyc();
        out_ready = 1'b1;
      end
      check("random", {out_valid, ox, oy, oz, out_sat}, {1'b1, e});
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
